// File: rtl/mod_seq_ctrl_if.sv
// Source bit handshake plus modulator input/output taps seen by the frame sequencer.
// master = sequencer side, slave = source/modulator side.
interface mod_seq_ctrl_if;
    logic src_dat;
    logic src_vld;
    logic src_rdy;
    logic mod_sig_di;
    logic mod_sig_di_vld;
    logic mod_pld_di;
    logic mod_pld_di_vld;
    logic mod_sig_do_vld;
    logic mod_pld_do_sym_end;
    logic mod_pld_do_vld;

    modport master (
        input  src_dat, src_vld, mod_sig_do_vld, mod_pld_do_sym_end, mod_pld_do_vld,
        output src_rdy, mod_sig_di, mod_sig_di_vld, mod_pld_di, mod_pld_di_vld
    );

    modport slave (
        output src_dat, src_vld, mod_sig_do_vld, mod_pld_do_sym_end, mod_pld_do_vld,
        input  src_rdy, mod_sig_di, mod_sig_di_vld, mod_pld_di, mod_pld_di_vld
    );
endinterface

// File: rtl/mod_seq_ctrl.sv
// Frame sequencer: signal field then zero-padded payload symbols to the modulator, 1-cycle registered latency.
// Never stalls the modulator; a source gap is zero-filled and flagged; done once all modulator outputs are seen.
module mod_seq_ctrl #(
    parameter int SIG_BITS = 48,
    parameter int SYM_BITS = 192,
    parameter int SIG_OUT  = 48,
    parameter int LEN_W    = 16
) (
    input  logic             mctl_clk,
    input  logic             mctl_rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] pld_bits,
    mod_seq_ctrl_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             underrun
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SIG   = 3'd1;
    localparam logic [2:0] S_PLD   = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int BC_W = $clog2((SYM_BITS > SIG_BITS) ? SYM_BITS : SIG_BITS);
    localparam int SO_W = $clog2(SIG_OUT + 1);
    localparam logic [BC_W-1:0] SIG_LAST = BC_W'(SIG_BITS - 1);
    localparam logic [BC_W-1:0] SYM_LAST = BC_W'(SYM_BITS - 1);
    localparam logic [SO_W-1:0] SIG_OUT_C = SO_W'(SIG_OUT);

    logic [2:0]       state;
    logic [BC_W-1:0]  bcnt;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] sym_iss;
    logic [LEN_W-1:0] sym_end_cnt;
    logic [SO_W-1:0]  sig_out_cnt;
    logic             src_bit;

    assign src_bit     = bus.src_vld & bus.src_dat;
    assign bus.src_rdy = (state == S_SIG) || (state == S_PLD);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_ff @(posedge mctl_clk or negedge mctl_rst_n) begin
        if (!mctl_rst_n) begin
            state              <= S_IDLE;
            bcnt               <= '0;
            rem                <= '0;
            sym_iss            <= '0;
            sym_end_cnt        <= '0;
            sig_out_cnt        <= '0;
            underrun           <= 1'b0;
            bus.mod_sig_di     <= 1'b0;
            bus.mod_sig_di_vld <= 1'b0;
            bus.mod_pld_di     <= 1'b0;
            bus.mod_pld_di_vld <= 1'b0;
        end else begin
            bus.mod_sig_di     <= 1'b0;
            bus.mod_sig_di_vld <= 1'b0;
            bus.mod_pld_di     <= 1'b0;
            bus.mod_pld_di_vld <= 1'b0;

            // A symbol end can never legitimately precede its issue, so sym_iss is the ceiling.
            if (state != S_IDLE) begin
                if (bus.mod_sig_do_vld && (sig_out_cnt != SIG_OUT_C))
                    sig_out_cnt <= sig_out_cnt + 1'b1;
                if (bus.mod_pld_do_sym_end && bus.mod_pld_do_vld && (sym_end_cnt < sym_iss))
                    sym_end_cnt <= sym_end_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem         <= pld_bits;
                        underrun    <= 1'b0;
                        sym_iss     <= '0;
                        sym_end_cnt <= '0;
                        sig_out_cnt <= '0;
                        bcnt        <= '0;
                        state       <= S_SIG;
                    end
                end
                S_SIG: begin
                    bus.mod_sig_di     <= src_bit;
                    bus.mod_sig_di_vld <= 1'b1;
                    if (!bus.src_vld)
                        underrun <= 1'b1;
                    if (bcnt == SIG_LAST) begin
                        bcnt  <= '0;
                        state <= (rem != '0) ? S_PLD : S_DRAIN;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                S_PLD: begin
                    bus.mod_pld_di     <= src_bit;
                    bus.mod_pld_di_vld <= 1'b1;
                    if (!bus.src_vld)
                        underrun <= 1'b1;
                    rem <= rem - 1'b1;
                    if (bcnt == SYM_LAST) begin
                        bcnt    <= '0;
                        sym_iss <= sym_iss + 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                    if (rem == LEN_W'(1))
                        state <= (bcnt == SYM_LAST) ? S_DRAIN : S_PAD;
                end
                S_PAD: begin
                    bus.mod_pld_di_vld <= 1'b1;
                    if (bcnt == SYM_LAST) begin
                        bcnt    <= '0;
                        sym_iss <= sym_iss + 1'b1;
                        state   <= S_DRAIN;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if ((sig_out_cnt == SIG_OUT_C) && (sym_end_cnt == sym_iss))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Randomized scoreboard bench for mod_seq_ctrl with a latency-modelled modulator.
`timescale 1ns/1ps
module tb_mod_seq_ctrl;
    localparam int SIG_BITS = 48;
    localparam int SYM_BITS = 192;
    localparam int LAT      = 5;

    typedef struct {
        logic b;
        int   t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pld_bits = '0;
    logic        busy, done, underrun;

    mod_seq_ctrl_if bus();

    mod_seq_ctrl dut (
        .mctl_clk   (clk),
        .mctl_rst_n (rst_n),
        .start      (start),
        .pld_bits   (pld_bits),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int   checks = 0, failures = 0, cyc = 0;
    exp_t sig_q[$], pld_q[$];
    int   sigp_q[$], symp_q[$];
    int   rdy_cnt = 0, done_cnt = 0, done_cyc = -100, last_pulse = 0, pbits = 0;
    bit   extra_sym = 1'b0;
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (bus.src_rdy) rdy_cnt++;
            if (bus.mod_sig_di_vld) begin
                chk("sig_expected", sig_q.size() != 0, 1);
                if (sig_q.size() != 0) begin
                    me = sig_q.pop_front();
                    chk("sig_bit", bus.mod_sig_di, me.b);
                    chk("sig_time", cyc, me.t);
                end
                sigp_q.push_back(cyc + LAT);
            end
            if (bus.mod_pld_di_vld) begin
                chk("pld_expected", pld_q.size() != 0, 1);
                if (pld_q.size() != 0) begin
                    me = pld_q.pop_front();
                    chk("pld_bit", bus.mod_pld_di, me.b);
                    chk("pld_time", cyc, me.t);
                end
                pbits++;
                if (pbits % SYM_BITS == 0) symp_q.push_back(cyc + LAT);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Modulator model: one output pulse per issued signal bit / payload symbol, LAT cycles later, plus noise
    initial begin
        bus.mod_sig_do_vld     = 1'b0;
        bus.mod_pld_do_vld     = 1'b0;
        bus.mod_pld_do_sym_end = 1'b0;
        forever begin
            tick();
            bus.mod_sig_do_vld     = 1'b0;
            bus.mod_pld_do_vld     = 1'b0;
            bus.mod_pld_do_sym_end = 1'b0;
            if (sigp_q.size() != 0 && sigp_q[0] <= cyc) begin
                void'(sigp_q.pop_front());
                bus.mod_sig_do_vld = 1'b1;
                last_pulse = cyc;
            end
            if (symp_q.size() != 0 && symp_q[0] <= cyc) begin
                void'(symp_q.pop_front());
                bus.mod_pld_do_vld     = 1'b1;
                bus.mod_pld_do_sym_end = 1'b1;
                last_pulse = cyc;
            end else if (extra_sym) begin
                bus.mod_pld_do_vld     = 1'b1;
                bus.mod_pld_do_sym_end = 1'b1;
                extra_sym = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) bus.mod_pld_do_sym_end = 1'b1;
                else                           bus.mod_pld_do_vld = 1'b1;
            end
        end
    end

    // gap_mode: 0 none, 1 three-cycle gap mid-payload, 2 random gaps
    task automatic run_frame(input int n, input int gap_mode, input bit extra, input int abort_k);
        int   padded, span, c1, d0, w;
        bit   exp_ur;
        bit   v[$];
        bit   d[$];
        exp_t e;
        padded = ((n + SYM_BITS - 1) / SYM_BITS) * SYM_BITS;
        span   = SIG_BITS + padded;
        exp_ur = 1'b0;
        for (int i = 0; i < SIG_BITS + n; i++) begin
            bit vv, dd;
            if (gap_mode == 0)      vv = 1'b1;
            else if (gap_mode == 1) vv = !(i >= SIG_BITS + 50 && i < SIG_BITS + 53);
            else                    vv = ($urandom_range(0, 9) != 0);
            dd = 1'($urandom_range(0, 1));
            v.push_back(vv);
            d.push_back(dd);
            if (!vv) exp_ur = 1'b1;
        end
        rdy_cnt  = 0;
        pbits    = 0;
        d0       = done_cnt;
        pld_bits = 16'(n);
        start    = 1'b1;
        tick();
        start = 1'b0;
        c1    = cyc;
        chk("busy_after_start", busy, 1);
        chk("underrun_cleared", underrun, 0);
        for (int k = 0; k < span; k++) begin
            e.t = c1 + 1 + k;
            e.b = (k < SIG_BITS + n) ? (v[k] & d[k]) : 1'b0;
            if (k < SIG_BITS) sig_q.push_back(e);
            else              pld_q.push_back(e);
        end
        for (int k = 0; k < span; k++) begin
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {busy, done, underrun, bus.src_rdy, bus.mod_sig_di, bus.mod_sig_di_vld,
                     bus.mod_pld_di, bus.mod_pld_di_vld}, 0);
                sig_q.delete();
                pld_q.delete();
                sigp_q.delete();
                symp_q.delete();
                bus.src_vld = 1'b0;
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (40) tick();
                chk("abort_no_done", done_cnt - d0, 0);
                chk("abort_idle", busy, 0);
                return;
            end
            if (k < SIG_BITS + n) begin
                bus.src_vld = v[k];
                bus.src_dat = d[k];
            end else begin
                bus.src_vld = 1'($urandom_range(0, 1));
                bus.src_dat = 1'($urandom_range(0, 1));
            end
            if (extra && k == 10) extra_sym = 1'b1;
            if (extra && k == SIG_BITS + 20) begin
                start    = 1'b1;
                pld_bits = 16'd7;
            end
            if (extra && k == SIG_BITS + 21) start = 1'b0;
            tick();
        end
        bus.src_vld = 1'b0;
        w = 0;
        while (done_cnt == d0 && w < 3000) begin
            tick();
            w++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("done_time", done_cyc, last_pulse + 2);
        chk("busy_after_done", busy, 0);
        chk("underrun", underrun, exp_ur);
        chk("src_rdy_cycles", rdy_cnt, SIG_BITS + n);
        chk("sig_q_drained", sig_q.size(), 0);
        chk("pld_q_drained", pld_q.size(), 0);
        repeat (10) tick();
        chk("done_once", done_cnt - d0, 1);
        chk("underrun_hold", underrun, exp_ur);
    endtask

    initial begin
        bus.src_vld = 1'b0;
        bus.src_dat = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs_zero",
            {busy, done, underrun, bus.src_rdy, bus.mod_sig_di, bus.mod_sig_di_vld,
             bus.mod_pld_di, bus.mod_pld_di_vld}, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_after_reset", busy, 0);

        run_frame(384, 0, 1'b0, -1);
        run_frame(200, 0, 1'b0, -1);
        run_frame(0,   0, 1'b0, -1);
        run_frame(300, 1, 1'b0, -1);
        run_frame(250, 0, 1'b1, -1);
        run_frame(200, 0, 1'b0, 300);
        run_frame(192, 0, 1'b0, -1);
        for (int r = 0; r < 4; r++)
            run_frame(int'($urandom_range(1, 500)), 2, 1'b0, -1);
        run_frame(1, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
